// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module   : register_file
//  Purpose  : 32 x 32 MIPS register file, two async read ports, one sync write
//             port, r0 hardwired to zero. Optional write-through forwarding is
//             enabled by defining REGFILE_WRITE_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Per-entry decode keeps an unknown address or enable from touching other entries.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rst) begin
                regs_d[i] = '0;
            end else if (reg_write && (write_reg == ADDR_WIDTH'(i))) begin
                regs_d[i] = write_data;
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    logic [DATA_WIDTH-1:0] stored1;
    logic [DATA_WIDTH-1:0] stored2;

    always_comb begin
        stored1 = (read_reg1 == '0) ? '0 : regs_q[read_reg1];
        stored2 = (read_reg2 == '0) ? '0 : regs_q[read_reg2];
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic fwd_valid;
    logic fwd1;
    logic fwd2;

    always_comb begin
        fwd_valid  = reg_write && !rst && (write_reg != '0);
        fwd1       = fwd_valid && (write_reg == read_reg1);
        fwd2       = fwd_valid && (write_reg == read_reg2);
        read_data1 = fwd1 ? write_data : stored1;
        read_data2 = fwd2 ? write_data : stored2;
    end
`else
    always_comb begin
        read_data1 = stored1;
        read_data2 = stored2;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// Directed self-checking bench for register_file.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int total;
    int bad;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] e1, input logic [31:0] e2, input string tag);
        read_reg1 = a1;
        read_reg2 = a2;
        #1;
        check({tag, "_p1"}, read_data1, e1);
        check({tag, "_p2"}, read_data2, e2);
    endtask

    logic [4:0]  wr_addr [6] = '{5'd0, 5'd2, 5'd4, 5'd8, 5'd16, 5'd31};
    logic [31:0] wr_val  [6] = '{32'd20, 32'd40, 32'd80, 32'd160, 32'd320, 32'd640};
    logic [31:0] pre_exp;

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;

        // Reset state: every address reads zero on both ports.
        tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            read_pair(5'(a), 5'(31 - a), 32'd0, 32'd0, "reset_all");
        end

        // Write sequence, one register per edge.
        reg_write = 1'b1;
        for (int k = 0; k < 6; k++) begin
            write_reg  = wr_addr[k];
            write_data = wr_val[k];
            tick();
        end
        reg_write = 1'b0;
        read_pair(5'd0,  5'd2,  32'd0,   32'd40,  "wr_0_2");
        read_pair(5'd4,  5'd8,  32'd80,  32'd160, "wr_4_8");
        read_pair(5'd16, 5'd31, 32'd320, 32'd640, "wr_16_31");
        read_pair(5'd1,  5'd30, 32'd0,   32'd0,   "untouched");

        // Write disabled over several edges.
        write_reg  = 5'd2;
        write_data = 32'd999;
        repeat (3) tick();
        read_pair(5'd2, 5'd2, 32'd40, 32'd40, "wr_disabled");

        // Same-address read and write.
        read_reg1  = 5'd4;
        read_reg2  = 5'd4;
        write_reg  = 5'd4;
        write_data = 32'd123;
        reg_write  = 1'b1;
`ifdef REGFILE_WRITE_BYPASS_EN
        pre_exp = 32'd123;
`else
        pre_exp = 32'd80;
`endif
        #1;
        check("same_pre_p1", read_data1, pre_exp);
        check("same_pre_p2", read_data2, pre_exp);
        tick();
        reg_write = 1'b0;
        read_pair(5'd4, 5'd4, 32'd123, 32'd123, "same_post");

        // r0 immunity, before and after the write edge.
        read_reg1  = 5'd0;
        read_reg2  = 5'd2;
        write_reg  = 5'd0;
        write_data = 32'hFFFF_FFFF;
        reg_write  = 1'b1;
        #1;
        check("r0_pre", read_data1, 32'd0);
        tick();
        check("r0_post", read_data1, 32'd0);
        check("r0_other", read_data2, 32'd40);
        reg_write = 1'b0;

        // Unknown write address must leave the other registers intact.
        write_reg  = 5'bx;
        write_data = 32'd55;
        reg_write  = 1'b1;
        tick();
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        read_pair(5'd2, 5'd8, 32'd40, 32'd160, "x_addr");
        read_pair(5'd31, 5'd0, 32'd640, 32'd0, "x_addr_b");

        // Reset has priority over a simultaneous write.
        rst        = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd31;
        write_data = 32'd7;
        tick();
        rst       = 1'b0;
        reg_write = 1'b0;
        read_pair(5'd31, 5'd2,  32'd0, 32'd0, "rst_prio_a");
        read_pair(5'd4,  5'd8,  32'd0, 32'd0, "rst_prio_b");
        read_pair(5'd16, 5'd0,  32'd0, 32'd0, "rst_prio_c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
